// File: rtl/buffer_m_sequencer_pkg.sv
// Shared constants for the bufferM metadata sequencer: FSM encoding,
// skid FIFO depth and the issue credit limit.
package buffer_m_sequencer_pkg;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam int FIFO_DEPTH = 4;
  localparam int CREDIT_MAX = 2;

  // Words already buffered plus the one read still in the ROM pipeline must
  // leave room for the read issued now and one more that may land before
  // the consumer's stall is seen.
  function automatic logic credit_ok(input logic [2:0] fifo_count, input logic inflight);
    return (int'(fifo_count) + int'(inflight)) <= CREDIT_MAX;
  endfunction

endpackage

// File: rtl/buffer_m_sequencer_if.sv
// Control, ROM and stream signals of the bufferM sequencer.
// master = the sequencer, slave = PE control / ROM / operand path.
interface buffer_m_sequencer_if #(
  parameter int addrLen = 10,
  parameter int dataLen = 32,
  parameter int cntLen  = 11
) ();

  logic               start;
  logic [addrLen-1:0] base_addr;
  logic [addrLen-1:0] stride;
  logic [cntLen-1:0]  count;
  logic [addrLen-1:0] rd_addr;
  logic [dataLen-1:0] rom_data;
  logic [dataLen-1:0] out_data;
  logic               out_valid;
  logic               out_ready;
  logic               busy;
  logic               done;

  modport master (
    input  start, base_addr, stride, count, rom_data, out_ready,
    output rd_addr, out_data, out_valid, busy, done
  );

  modport slave (
    output start, base_addr, stride, count, rom_data, out_ready,
    input  rd_addr, out_data, out_valid, busy, done
  );

endinterface

// File: rtl/buffer_m_skid_fifo.sv
// 4-entry synchronous FIFO with a registered head word. A push and a pop in
// the same cycle are both honoured; a push into a full FIFO without a pop
// is dropped (the sequencer's credit rule keeps that from happening).
import buffer_m_sequencer_pkg::*;

module buffer_m_skid_fifo #(
  parameter int dataLen = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               i_push,
  input  logic [dataLen-1:0] i_push_data,
  input  logic               i_pop,
  output logic [dataLen-1:0] o_head,
  output logic [2:0]         o_count,
  output logic               o_empty
);

  logic [dataLen-1:0] r_mem [FIFO_DEPTH];
  logic [dataLen-1:0] r_head;
  logic [1:0]         r_rd_ptr;
  logic [1:0]         r_wr_ptr;
  logic [2:0]         r_count;

  logic               w_do_pop;
  logic               w_do_push;
  logic [1:0]         w_rd_next;

  assign w_do_pop  = i_pop && (r_count != 3'd0);
  assign w_do_push = i_push && ((r_count != 3'(FIFO_DEPTH)) || w_do_pop);
  assign w_rd_next = r_rd_ptr + {1'b0, w_do_pop};

  // Storage array: write the pushed word at the write pointer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_rd_ptr <= w_rd_next;
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 2'd1;
      r_count <= r_count + {2'b0, w_do_push} - {2'b0, w_do_pop};
    end
  end

  // Head register: take the incoming word directly when it lands in the
  // slot that becomes the head (FIFO empty after this cycle's pop).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_head <= '0;
    end else if (w_do_push && (r_wr_ptr == w_rd_next)) begin
      r_head <= i_push_data;
    end else begin
      r_head <= r_mem[w_rd_next];
    end
  end

  assign o_head  = r_head;
  assign o_count = r_count;
  assign o_empty = (r_count == 3'd0);

endmodule

// File: rtl/buffer_m_sequencer.sv
// Streams a strided run of bufferM words onto a valid/ready stream, hiding
// the ROM's one-cycle read latency behind a small credit-managed FIFO.
//
// state | meaning
// IDLE  | waiting for start; count=0 start only pulses done
// ISSUE | presenting one ROM address per cycle while credit allows
// DRAIN | all addresses issued; waiting for the last word to transfer
import buffer_m_sequencer_pkg::*;

module buffer_m_sequencer #(
  parameter int addrLen = 10,
  parameter int dataLen = 32,
  parameter int cntLen  = 11
) (
  input logic                  clk,
  input logic                  reset_n,
  buffer_m_sequencer_if.master bus
);

  logic [1:0]         r_state;
  logic [addrLen-1:0] r_rd_addr;
  logic [addrLen-1:0] r_stride;
  logic [cntLen-1:0]  r_issue_left;
  logic [cntLen-1:0]  r_xfer_left;
  logic               r_inflight;
  logic               r_done_zero;

  logic [dataLen-1:0] w_fifo_head;
  logic [2:0]         w_fifo_count;
  logic               w_fifo_empty;
  logic               w_accept;
  logic               w_issue;
  logic               w_pop;
  logic               w_last_xfer;

  assign w_accept    = (r_state == ST_IDLE) && bus.start && (bus.count != '0);
  assign w_issue     = (r_state == ST_ISSUE) && credit_ok(w_fifo_count, r_inflight);
  assign w_pop       = !w_fifo_empty && bus.out_ready;
  assign w_last_xfer = w_pop && (r_state != ST_IDLE) && (r_xfer_left == cntLen'(1));

  // Run control: state, issue budget, transfer budget and the count=0 done.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_stride     <= '0;
      r_issue_left <= '0;
      r_xfer_left  <= '0;
      r_done_zero  <= 1'b0;
    end else begin
      r_done_zero <= 1'b0;
      if (w_pop && (r_state != ST_IDLE)) r_xfer_left <= r_xfer_left - cntLen'(1);
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state      <= ST_ISSUE;
            r_stride     <= bus.stride;
            r_issue_left <= bus.count;
            r_xfer_left  <= bus.count;
          end else if (bus.start) begin
            r_done_zero <= 1'b1;
          end
        end
        ST_ISSUE: begin
          if (w_issue) begin
            r_issue_left <= r_issue_left - cntLen'(1);
            if (r_issue_left == cntLen'(1)) r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (w_last_xfer) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Read address: load base on accept, step by stride after every issue but
  // the last, so rd_addr rests on the final address of the run.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_addr <= '0;
    end else if (w_accept) begin
      r_rd_addr <= bus.base_addr;
    end else if (w_issue && (r_issue_left != cntLen'(1))) begin
      r_rd_addr <= r_rd_addr + r_stride;
    end
  end

  // ROM data is valid the cycle after an issue; remember which cycles those are.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_inflight <= 1'b0;
    else          r_inflight <= w_issue;
  end

  buffer_m_skid_fifo #(
    .dataLen(dataLen)
  ) u_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_push      (r_inflight),
    .i_push_data (bus.rom_data),
    .i_pop       (w_pop),
    .o_head      (w_fifo_head),
    .o_count     (w_fifo_count),
    .o_empty     (w_fifo_empty)
  );

  assign bus.rd_addr   = r_rd_addr;
  assign bus.out_data  = w_fifo_head;
  assign bus.out_valid = !w_fifo_empty;
  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.done      = r_done_zero | w_last_xfer;

endmodule

// File: tb/tb_buffer_m_sequencer.sv
// Bench for buffer_m_sequencer: a queue model of each run's word order and
// done/busy behaviour, checked every cycle, plus directed literal checks.
module tb_buffer_m_sequencer;

  logic clk = 1'b0;
  logic reset_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  buffer_m_sequencer_if bus_if ();

  buffer_m_sequencer dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if)
  );

  always #5 clk = ~clk;

  // bufferM contents as seen by peId 1: word 0 is the id, 1..7 zero,
  // everything else a tagged copy of its address.
  function automatic logic [31:0] rom_f(input logic [9:0] a);
    if (a == 10'd0)      return 32'h1;
    else if (a < 10'd8)  return 32'h0;
    else                 return 32'hA500_0000 | {22'd0, a};
  endfunction

  always @(posedge clk) bus_if.rom_data <= rom_f(bus_if.rd_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- model + per-cycle compare ----------------
  logic [31:0] exp_q[$];
  int          m_left = 0;
  bit          m_busy = 1'b0;
  bit          m_zero = 1'b0;

  always @(negedge clk) begin
    bit          xfer;
    bit          exp_done;
    bit          nb;
    logic [9:0]  a;
    if (!reset_n) begin
      exp_q.delete();
      m_left = 0;
      m_busy = 1'b0;
      m_zero = 1'b0;
    end else begin
      xfer     = bus_if.out_valid && bus_if.out_ready;
      exp_done = m_zero || (xfer && (m_left == 1));
      check("busy", 32'(bus_if.busy), 32'(m_busy));
      check("done", 32'(bus_if.done), 32'(exp_done));
      check("fifo_le_4", 32'(dut.w_fifo_count <= 3'd4), 32'd1);
      nb = m_busy;
      if (xfer) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL extra_word: actual=%0h required=no transfer", bus_if.out_data);
        end else begin
          check("out_data", bus_if.out_data, exp_q.pop_front());
        end
        if (m_left == 1) nb = 1'b0;
        if (m_left > 0) m_left--;
      end
      m_zero = 1'b0;
      if (bus_if.start && !m_busy) begin
        if (bus_if.count != 11'd0) begin
          a = bus_if.base_addr;
          for (int k = 0; k < int'(bus_if.count); k++) begin
            exp_q.push_back(rom_f(a));
            a = a + bus_if.stride;
          end
          m_left = int'(bus_if.count);
          nb     = 1'b1;
        end else begin
          m_zero = 1'b1;
        end
      end
      m_busy = nb;
    end
  end

  // ---------------- directed stimulus ----------------
  logic [31:0] cap_words[$];
  logic [9:0]  cap_addrs[$];
  int          first_valid;
  int          done_k;
  int          ndone;
  int          nxfer;
  bit          any_busy;
  logic [9:0]  addr_c1;

  // Pulse start (sampled at edge 0), then observe cycles 1..max_c.
  // slow: out_ready high only every third cycle (2 low, 1 high).
  // restart_k: cycle in which a second start is pulsed (0 = none).
  task automatic run(input logic [9:0] b, input logic [9:0] s, input logic [10:0] n,
                     input bit slow, input int restart_k, input int max_c);
    cap_words.delete();
    cap_addrs.delete();
    first_valid = 0;
    done_k      = 0;
    ndone       = 0;
    nxfer       = 0;
    any_busy    = 1'b0;
    @(posedge clk); #1;
    bus_if.base_addr = b;
    bus_if.stride    = s;
    bus_if.count     = n;
    bus_if.start     = 1'b1;
    bus_if.out_ready = 1'b1;
    @(posedge clk); #1;
    bus_if.start = 1'b0;
    for (int k = 1; k <= max_c; k++) begin
      bus_if.out_ready = slow ? ((k % 3) == 2) : 1'b1;
      if (k == restart_k) begin
        bus_if.count = 11'd5;
        bus_if.start = 1'b1;
      end else begin
        bus_if.start = 1'b0;
      end
      @(negedge clk);
      if (k == 1) addr_c1 = bus_if.rd_addr;
      if (bus_if.busy) begin
        any_busy = 1'b1;
        if (cap_addrs.size() == 0 || bus_if.rd_addr != cap_addrs[$]) cap_addrs.push_back(bus_if.rd_addr);
      end
      if (bus_if.out_valid && first_valid == 0) first_valid = k;
      if (bus_if.out_valid && bus_if.out_ready) begin
        cap_words.push_back(bus_if.out_data);
        nxfer++;
      end
      if (bus_if.done) begin
        ndone++;
        if (done_k == 0) done_k = k;
      end
      @(posedge clk); #1;
    end
    bus_if.start     = 1'b0;
    bus_if.out_ready = 1'b1;
  endtask

  initial begin
    reset_n          = 1'b0;
    bus_if.start     = 1'b0;
    bus_if.base_addr = '0;
    bus_if.stride    = '0;
    bus_if.count     = '0;
    bus_if.out_ready = 1'b1;

    #12;
    check("rst_rd_addr", 32'(bus_if.rd_addr), 32'd0);
    check("rst_out_valid", 32'(bus_if.out_valid), 32'd0);
    check("rst_out_data", bus_if.out_data, 32'd0);
    check("rst_busy", 32'(bus_if.busy), 32'd0);
    check("rst_done", 32'(bus_if.done), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // peId 1 sweep: 0x1 then seven zeros; first valid cycle 3, done cycle 10
    run(10'd0, 10'd1, 11'd8, 1'b0, 0, 14);
    check("t1_first_valid", 32'(first_valid), 32'd3);
    check("t1_done_cycle", 32'(done_k), 32'd10);
    check("t1_ndone", 32'(ndone), 32'd1);
    check("t1_nxfer", 32'(nxfer), 32'd8);
    if (cap_words.size() == 8) begin
      check("t1_word0", cap_words[0], 32'h1);
      for (int i = 1; i < 8; i++) check("t1_wordn", cap_words[i], 32'h0);
    end

    // wrap-around addressing
    run(10'd1020, 10'd3, 11'd4, 1'b0, 0, 10);
    check("t2_naddr", 32'(cap_addrs.size()), 32'd4);
    if (cap_addrs.size() == 4) begin
      check("t2_addr0", 32'(cap_addrs[0]), 32'd1020);
      check("t2_addr1", 32'(cap_addrs[1]), 32'd1023);
      check("t2_addr2", 32'(cap_addrs[2]), 32'd2);
      check("t2_addr3", 32'(cap_addrs[3]), 32'd5);
    end
    check("t2_done_cycle", 32'(done_k), 32'd6);

    // backpressure 2-low/1-high: transfers in cycles 5,8,...,62
    run(10'd100, 10'd7, 11'd20, 1'b1, 0, 70);
    check("t3_nxfer", 32'(nxfer), 32'd20);
    check("t3_ndone", 32'(ndone), 32'd1);
    check("t3_done_cycle", 32'(done_k), 32'd62);
    if (cap_words.size() == 20) check("t3_last_word", cap_words[19], 32'hA500_00E9);

    // count=0: done in cycle 1, never busy, rd_addr stays at 100+7*19
    run(10'd500, 10'd5, 11'd0, 1'b0, 0, 4);
    check("t4_done_cycle", 32'(done_k), 32'd1);
    check("t4_ndone", 32'(ndone), 32'd1);
    check("t4_busy", 32'(any_busy), 32'd0);
    check("t4_rd_addr", 32'(addr_c1), 32'd233);

    // second start during DRAIN (cycle 4) is ignored
    run(10'd50, 10'd2, 11'd3, 1'b0, 4, 12);
    check("t5_ndone", 32'(ndone), 32'd1);
    check("t5_nxfer", 32'(nxfer), 32'd3);
    check("t5_done_cycle", 32'(done_k), 32'd5);
    check("t5_idle", 32'(bus_if.busy), 32'd0);

    // asynchronous reset mid-run, then a clean run
    @(posedge clk); #1;
    bus_if.base_addr = 10'd300;
    bus_if.stride    = 10'd1;
    bus_if.count     = 11'd16;
    bus_if.start     = 1'b1;
    @(posedge clk); #1;
    bus_if.start = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("t6_rd_addr", 32'(bus_if.rd_addr), 32'd0);
    check("t6_out_valid", 32'(bus_if.out_valid), 32'd0);
    check("t6_out_data", bus_if.out_data, 32'd0);
    check("t6_busy", 32'(bus_if.busy), 32'd0);
    check("t6_done", 32'(bus_if.done), 32'd0);
    check("t6_fifo_count", 32'(dut.w_fifo_count), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    run(10'd200, 10'd1, 11'd4, 1'b0, 0, 10);
    check("t6_nxfer", 32'(nxfer), 32'd4);
    check("t6_ndone", 32'(ndone), 32'd1);
    check("t6_done_cycle", 32'(done_k), 32'd6);
    if (cap_words.size() == 4) begin
      check("t6_word0", cap_words[0], 32'hA500_00C8);
      check("t6_word3", cap_words[3], 32'hA500_00CB);
    end

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/buffer_m_sequencer.md
# buffer_m_sequencer

Streams a contiguous, strided run of per-PE metadata words out of the `bufferM` constant ROM into a PE datapath. Given a base address, stride and word count, it drives the ROM read address, compensates for the ROM's one-cycle registered read latency, and presents the words on a valid/ready stream. It sits between the PE control logic (start/done) and the PE operand path, which may stall.

## Interface
Parameters:
- `addrLen`, 10: ROM address width; matches `bufferM`.
- `dataLen`, 32: ROM data width; matches `bufferM`.
- `cntLen`, 11: word-count width (`addrLen+1`, so a full ROM sweep fits).

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `base_addr`  in  addrLen  first ROM address; sampled with `start`.
- `stride`  in  addrLen  address increment; sampled with `start`.
- `count`  in  cntLen  number of words; sampled with `start`.
- `rd_addr`  out  addrLen  to `bufferM.rd_addr`.
- `rom_data`  in  dataLen  from `bufferM.data_out`; valid one cycle after `rd_addr`.
- `out_data`  out  dataLen  stream data.
- `out_valid`  out  1  stream valid.
- `out_ready`  in  1  consumer ready; a transfer occurs when valid && ready.
- `busy`  out  1  high while a run is in progress.
- `done`  out  1  one-cycle pulse on the final transfer.

## Operation
- States: IDLE, ISSUE, DRAIN.
  - IDLE: `start` with `count`≠0 latches the run parameters and moves to ISSUE. `start` with `count`=0 pulses `done` on the next cycle, issues no reads, and stays in IDLE.
  - ISSUE: issues one address per cycle when the credit rule allows. After the last issue, moves to DRAIN.
  - DRAIN: waits until the in-flight read and the FIFO are both empty and the last word has transferred, then pulses `done` and returns to IDLE.
- `start` in ISSUE or DRAIN is ignored. There is no queued second run.
- Address generation: `rd_addr` is a register. The first issue presents `base_addr`; each following issue adds `stride`. Arithmetic is modulo 2^addrLen, so wrap-around is silent and legal.
- In-flight tracking: 1-bit `inflight` register equals "issued last cycle". When `inflight`=1, `rom_data` is written into a 4-entry FIFO.
- Credit rule: an issue in cycle t is allowed only if `fifo_count + inflight ≤ 2`. This guarantees the FIFO never overflows. Overflow is a bench assertion.
- Outputs: `out_valid` means the FIFO is not empty; `out_data` is the FIFO head. A pop and a push in the same cycle are both honoured.
- A remaining-words counter decrements on each issue. A separate transfer counter drives `done`.
- `busy` is high from the cycle after `start` is accepted through the `done` cycle inclusive. It is not raised for `count`=0.

## Timing
- Reset values: `rd_addr`=0, `out_valid`=0, `out_data`=0, `busy`=0, `done`=0, FIFO empty, state IDLE.
- Start latency, with `out_ready` held high:
  - `start` sampled at edge 0.
  - `rd_addr`=base during cycle 1.
  - `rom_data` valid during cycle 2.
  - `out_valid` first high during cycle 3.
- Throughput is 1 word per cycle with `out_ready` held high. A run of N words has its last transfer in cycle N+2; `done` is asserted in that same cycle.
- Backpressure: when `out_ready` is low, issue stops within 1 cycle. At most 4 words are buffered, and none are lost or duplicated.
- Asynchronous reset in mid-run aborts immediately:
  - FIFO and counters clear.
  - The in-flight read is discarded.
  - No `done` pulse is produced.

## Structure
- Shared package holds:
  - state encoding constants (IDLE/ISSUE/DRAIN);
  - `FIFO_DEPTH`=4;
  - `CREDIT_MAX`=2.
- One sub-module, `buffer_m_skid_fifo`: synchronous 4-entry FIFO with registered head, count output, and simultaneous push/pop support. The sequencer instantiates it once.

## Test plan
- Run (base=0, stride=1, count=8) with `out_ready`=1 against a `bufferM` model of peId 1 → words 0x1 followed by seven 0x0; first `out_valid` in cycle 3; `done` in cycle 10.
- Run (base=1020, stride=3, count=4), addrLen=10 → `rd_addr` sequence 1020, 1023, 2, 5.
- `out_ready` toggles in a 2-low/1-high pattern during a count=20 run → exactly 20 transfers in address order; `fifo_count` never exceeds 4.
- `start` with `count`=0 → `done` pulse in cycle 1, `busy` stays 0, `rd_addr` unchanged.
- Second `start` pulsed during DRAIN → ignored; exactly one `done` is produced.
- `reset_n` asserted low in the middle of a count=16 run → all outputs go to their reset values at once; a new run after reset completes normally with the correct data.
